phase_shift_ctrl: RTL and testbench
===================================

# phase_shift_ctrl

Sequencer that moves an MMCM's dynamic phase shift (PSEN/PSINCDEC/PSDONE) to a register-programmed target, one step at a time along the shortest path around the phase circle. It sits between the register block's 16-bit phase value and load strobe and the ADC/clkgen MMCM. It tracks the current phase, reports busy/done status, and flags timeouts and out-of-range requests.

## Interface
- pPHASE_WIDTH, 16: width of the signed phase request and of the current-phase output.
- pMAX_STEPS, 1120: number of PS steps in one full 360° rotation; the phase wraps modulo this value.
- pTIMEOUT, 255: clk_usb cycles allowed between PSEN and PSDONE before the step is abandoned.
- clk_usb  in  1  sole clock; the MMCM PSCLK is driven from the same clock.
- reset_n  in  1  synchronous, active-low reset.
- phase_i  in  pPHASE_WIDTH  signed target phase in steps; sampled on phase_ld_i.
- phase_ld_i  in  1  single-cycle load strobe.
- mmcm_locked_i  in  1  MMCM lock status.
- psdone_i  in  1  MMCM PSDONE, single-cycle pulse.
- psen_o  out  1  MMCM PSEN, single-cycle pulse per step.
- psincdec_o  out  1  1 = increment, 0 = decrement; valid while psen_o is high.
- phase_current_o  out  pPHASE_WIDTH  current phase, in the range 0..pMAX_STEPS-1.
- busy_o  out  1  high from the cycle after a load until done.
- done_o  out  1  one-cycle pulse when the target is reached.
- err_o  out  2  [0] timeout, [1] range clip. Both bits are sticky until the next phase_ld_i.

## Operation
- States:
  - IDLE: waits for phase_ld_i.
  - CALC: computes the step distance.
  - STEP: asserts psen_o.
  - WAIT: waits for psdone_i.
  - DONE: pulses done_o.
- Load normalisation:
  - If phase_i < 0, the target is phase_i + pMAX_STEPS.
  - A result below 0 is clipped to 0; a result at or above pMAX_STEPS is clipped to pMAX_STEPS-1. Either clip sets err_o[1].
- CALC:
  - diff = target − current, computed with pPHASE_WIDTH+2 bits signed.
  - If diff > pMAX_STEPS/2, subtract pMAX_STEPS. If diff < −pMAX_STEPS/2, add pMAX_STEPS.
  - diff == 0 goes to DONE. Otherwise go to STEP with remaining = |diff| and dir = (diff > 0).
- STEP: assert psen_o for exactly one cycle, with psincdec_o = dir. Go to WAIT.
- WAIT, on psdone_i:
  - Update current by ±1 modulo pMAX_STEPS: incrementing from pMAX_STEPS-1 gives 0; decrementing from 0 gives pMAX_STEPS-1.
  - Decrement remaining. Go to STEP if remaining is still nonzero, otherwise to DONE.
- Load while busy:
  - The new normalised target is latched as pending.
  - An in-flight step is never aborted. After its PSDONE the FSM returns to CALC with the pending target.
- Timeout: if psdone_i has not arrived pTIMEOUT cycles after psen_o, set err_o[0] and go to IDLE. current is not updated and done_o is not pulsed.
- mmcm_locked_i low in any state:
  - Go to IDLE, force current to 0, clear busy_o, discard any pending target.
  - psen_o is never asserted while unlocked.
  - A load received while unlocked is dropped.
- psdone_i outside WAIT is ignored.
- Reset values (reset_n low at a clock edge): state IDLE, psen_o 0, psincdec_o 0, phase_current_o 0, busy_o 0, done_o 0, err_o 0, pending cleared.

## Timing
- phase_ld_i high in cycle N. CALC runs in N+1 with busy_o high. The first psen_o is in N+2.
- Zero-distance load: done_o pulses in N+2, busy_o drops in N+3, and psen_o is never asserted.
- psdone_i in cycle M: phase_current_o updates in M+1. The next psen_o is in M+1 at the earliest.
- Last psdone_i in cycle M: done_o pulses in M+1, busy_o low in M+2.
- A load coinciding with psdone_i is honoured: the step is counted, then CALC runs with the new target.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package:
  - State encoding.
  - err_o bit indices.
  - Default pMAX_STEPS and pTIMEOUT constants, also used by the register block and by Python-facing documentation.
- One sub-module, phase_shortest_path: combinational normalisation plus wrap-aware diff and direction. It is reused by CALC and exercised by a standalone unit test.
- Integration: the register block's phase outputs feed phase_i and phase_ld_i, and phase_current_o and busy_o are returned for readback.

## Test plan
All cases use pMAX_STEPS=1120 and an MMCM model that returns PSDONE 12 cycles after PSEN.
- Load 5 from 0 → five psen_o pulses with psincdec_o=1, phase_current_o=5, one done_o, err_o=0.
- Current 2, load −3 (target 1117) → five decrement steps through 1,0,1119,1118,1117; final phase_current_o=1117.
- Current 0, load 561 → 559 decrement steps (shortest path), final phase_current_o=561.
- Load 2000 → clipped to 1119, err_o=2'b10, one decrement step.
- While stepping toward 100 at current 40, load 30 → the in-flight step completes, then the FSM reverses to 30 and pulses done_o once.
- Model never returns PSDONE → err_o[0] set 255 cycles after psen_o, FSM in IDLE. Separately, drop mmcm_locked_i mid-move → phase_current_o=0, busy_o=0, no further psen_o.

Source files
------------

// File: rtl/phase_shift_ctrl_pkg.sv
// Shared definitions for the MMCM dynamic phase-shift sequencer: state encoding,
// error bit positions and the default rotation/timeout constants.
package phase_shift_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_STEP = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_RANGE   = 1;

    // One full 360 degree rotation of the MMCM fine phase shift, and the PSDONE wait limit.
    localparam int PS_MAX_STEPS = 1120;
    localparam int PS_TIMEOUT   = 255;

endpackage

// File: rtl/phase_shortest_path.sv
// Combinational helpers: normalise a signed phase request onto 0..MAX_STEPS-1 and
// find the shortest signed distance/direction from the current phase to a target.
module phase_shortest_path
    import phase_shift_ctrl_pkg::*;
#(
    parameter int W         = 16,
    parameter int MAX_STEPS = PS_MAX_STEPS
) (
    input  logic signed [W-1:0] phase_raw,
    output logic        [W-1:0] target_norm,
    output logic                clipped,
    input  logic        [W-1:0] target,
    input  logic        [W-1:0] current,
    output logic        [W+1:0] distance,
    output logic                dir,
    output logic                zero
);
    localparam int DW = W + 2;
    localparam logic signed [DW-1:0] MAX      = DW'(MAX_STEPS);
    localparam logic signed [DW-1:0] HALF     = DW'(MAX_STEPS / 2);
    localparam logic signed [DW-1:0] NEG_HALF = -HALF;

    logic signed [DW-1:0] raw_ext;
    logic signed [DW-1:0] wrapped;
    logic signed [DW-1:0] t_ext;
    logic signed [DW-1:0] c_ext;
    logic signed [DW-1:0] diff;
    logic signed [DW-1:0] diff_wrapped;

    always_comb begin
        raw_ext     = {{2{phase_raw[W-1]}}, phase_raw};
        wrapped     = raw_ext[DW-1] ? raw_ext + MAX : raw_ext;
        target_norm = wrapped[W-1:0];
        clipped     = 1'b0;
        if (wrapped[DW-1]) begin
            target_norm = '0;
            clipped     = 1'b1;
        end else if (wrapped >= MAX) begin
            target_norm = W'(MAX_STEPS - 1);
            clipped     = 1'b1;
        end
    end

    // Fold the raw difference into -MAX/2..+MAX/2 so the move never goes the long way round.
    always_comb begin
        t_ext = {2'b00, target};
        c_ext = {2'b00, current};
        diff  = t_ext - c_ext;
        if (diff > HALF) begin
            diff_wrapped = diff - MAX;
        end else if (diff < NEG_HALF) begin
            diff_wrapped = diff + MAX;
        end else begin
            diff_wrapped = diff;
        end
        zero     = (diff_wrapped == '0);
        dir      = !diff_wrapped[DW-1] && !zero;
        distance = diff_wrapped[DW-1] ? -diff_wrapped : diff_wrapped;
    end

endmodule

// File: rtl/phase_shift_ctrl.sv
// Steps an MMCM's dynamic phase shift (PSEN/PSINCDEC/PSDONE) one step at a time to a
// register-programmed target along the shortest path around the phase circle.
module phase_shift_ctrl
    import phase_shift_ctrl_pkg::*;
#(
    parameter int pPHASE_WIDTH = 16,
    parameter int pMAX_STEPS   = PS_MAX_STEPS,
    parameter int pTIMEOUT     = PS_TIMEOUT
) (
    input  logic                           clk_usb,
    input  logic                           reset_n,
    input  logic signed [pPHASE_WIDTH-1:0] phase_i,
    input  logic                           phase_ld_i,
    input  logic                           mmcm_locked_i,
    input  logic                           psdone_i,
    output logic                           psen_o,
    output logic                           psincdec_o,
    output logic        [pPHASE_WIDTH-1:0] phase_current_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic        [1:0]              err_o
);
    localparam int W  = pPHASE_WIDTH;
    localparam int DW = W + 2;
    localparam int TW = $clog2(pTIMEOUT + 1);
    localparam logic [W-1:0]  LAST       = W'(pMAX_STEPS - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(pTIMEOUT);

    state_t         state, state_next;
    logic [W-1:0]   current, current_next;
    logic [W-1:0]   target, target_next;
    logic [W-1:0]   pending, pending_next;
    logic           pending_valid, pending_valid_next;
    logic [DW-1:0]  remaining, remaining_next;
    logic [TW-1:0]  timer, timer_next;
    logic           psen, psen_next;
    logic           psincdec, psincdec_next;
    logic           busy, busy_next;
    logic           done, done_next;
    logic [1:0]     err, err_next;

    logic [W-1:0]   load_target;
    logic           load_clipped;
    logic [DW-1:0]  step_count;
    logic           step_dir;
    logic           step_zero;

    phase_shortest_path #(
        .W         (W),
        .MAX_STEPS (pMAX_STEPS)
    ) u_path (
        .phase_raw   (phase_i),
        .target_norm (load_target),
        .clipped     (load_clipped),
        .target      (target),
        .current     (current),
        .distance    (step_count),
        .dir         (step_dir),
        .zero        (step_zero)
    );

    always_ff @(posedge clk_usb) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            current       <= '0;
            target        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            remaining     <= '0;
            timer         <= '0;
            psen          <= 1'b0;
            psincdec      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= '0;
        end else begin
            state         <= state_next;
            current       <= current_next;
            target        <= target_next;
            pending       <= pending_next;
            pending_valid <= pending_valid_next;
            remaining     <= remaining_next;
            timer         <= timer_next;
            psen          <= psen_next;
            psincdec      <= psincdec_next;
            busy          <= busy_next;
            done          <= done_next;
            err           <= err_next;
        end
    end

    always_comb begin
        state_next         = state;
        current_next       = current;
        target_next        = target;
        pending_next       = pending;
        pending_valid_next = pending_valid;
        remaining_next     = remaining;
        timer_next         = timer;
        psen_next          = 1'b0;
        psincdec_next      = psincdec;
        busy_next          = busy;
        done_next          = 1'b0;
        err_next           = err;

        if (!mmcm_locked_i) begin
            state_next         = ST_IDLE;
            current_next       = '0;
            busy_next          = 1'b0;
            pending_valid_next = 1'b0;
            remaining_next     = '0;
        end else begin
            if (phase_ld_i) begin
                err_next            = '0;
                err_next[ERR_RANGE] = load_clipped;
            end
            // A load while moving is parked; the in-flight step always finishes first.
            if (phase_ld_i && state != ST_IDLE) begin
                pending_next       = load_target;
                pending_valid_next = 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (phase_ld_i) begin
                        target_next = load_target;
                        busy_next   = 1'b1;
                        state_next  = ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (step_zero) begin
                        done_next  = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        psen_next      = 1'b1;
                        psincdec_next  = step_dir;
                        remaining_next = step_count;
                        state_next     = ST_STEP;
                    end
                end
                ST_STEP: begin
                    timer_next = TW'(1);
                    state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    if (psdone_i) begin
                        if (psincdec) begin
                            current_next = (current == LAST) ? '0 : current + 1'b1;
                        end else begin
                            current_next = (current == '0) ? LAST : current - 1'b1;
                        end
                        remaining_next = remaining - 1'b1;
                        if (phase_ld_i || pending_valid) begin
                            target_next        = phase_ld_i ? load_target : pending;
                            pending_valid_next = 1'b0;
                            state_next         = ST_CALC;
                        end else if (remaining != DW'(1)) begin
                            psen_next  = 1'b1;
                            state_next = ST_STEP;
                        end else begin
                            done_next  = 1'b1;
                            state_next = ST_DONE;
                        end
                    end else if (timer == TIMER_LAST) begin
                        err_next[ERR_TIMEOUT] = 1'b1;
                        busy_next             = 1'b0;
                        pending_valid_next    = 1'b0;
                        state_next            = ST_IDLE;
                    end else begin
                        timer_next = timer + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (phase_ld_i || pending_valid) begin
                        target_next        = phase_ld_i ? load_target : pending;
                        pending_valid_next = 1'b0;
                        state_next         = ST_CALC;
                    end else begin
                        busy_next  = 1'b0;
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign psen_o          = psen;
    assign psincdec_o      = psincdec;
    assign phase_current_o = current;
    assign busy_o          = busy;
    assign done_o          = done;
    assign err_o           = err;

endmodule

// File: tb/tb_phase_shift_ctrl.sv
// Self-checking bench for phase_shift_ctrl: MMCM model answering PSDONE 12 cycles after
// PSEN, a phase-circle reference model checked every cycle, directed and random moves.
module tb_phase_shift_ctrl;

    localparam int MAX      = 1120;
    localparam int TIMEOUT  = 255;
    localparam int PS_DELAY = 12;

    logic               clk_usb = 1'b0;
    logic               reset_n = 1'b0;
    logic signed [15:0] phase_i = '0;
    logic               phase_ld_i = 1'b0;
    logic               mmcm_locked_i = 1'b1;
    logic               psdone_i = 1'b0;
    logic               psen_o;
    logic               psincdec_o;
    logic        [15:0] phase_current_o;
    logic               busy_o;
    logic               done_o;
    logic        [1:0]  err_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int psen_count = 0;
    int done_count = 0;
    bit respond = 1'b1;
    int countdown = 0;
    bit model_on = 1'b0;

    int       m_current = 0;
    int       m_target = 0;
    int       m_done_due = -1;
    int       m_psen_cyc = 0;
    bit       m_busy = 1'b0;
    bit       m_in_flight = 1'b0;
    bit       m_retarget = 1'b0;
    bit       m_step_dir = 1'b0;
    bit       m_locked_prev = 1'b1;
    bit [1:0] m_err = 2'b00;

    phase_shift_ctrl #(
        .pPHASE_WIDTH (16),
        .pMAX_STEPS   (MAX),
        .pTIMEOUT     (TIMEOUT)
    ) dut (
        .clk_usb         (clk_usb),
        .reset_n         (reset_n),
        .phase_i         (phase_i),
        .phase_ld_i      (phase_ld_i),
        .mmcm_locked_i   (mmcm_locked_i),
        .psdone_i        (psdone_i),
        .psen_o          (psen_o),
        .psincdec_o      (psincdec_o),
        .phase_current_o (phase_current_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o)
    );

    always #5 clk_usb = ~clk_usb;

    function automatic int norm_phase(input int p, output bit clip);
        int t;
        t    = (p < 0) ? p + MAX : p;
        clip = 1'b0;
        if (t < 0) begin
            t    = 0;
            clip = 1'b1;
        end else if (t >= MAX) begin
            t    = MAX - 1;
            clip = 1'b1;
        end
        return t;
    endfunction

    function automatic int fwd_dist(input int cur, input int tgt);
        return (((tgt - cur) % MAX) + MAX) % MAX;
    endfunction

    function automatic bit inc_dir(input int cur, input int tgt);
        int d;
        d = fwd_dist(cur, tgt);
        return (d != 0) && (d <= MAX / 2);
    endfunction

    function automatic int steps_between(input int cur, input int tgt);
        int d;
        d = fwd_dist(cur, tgt);
        return (d <= MAX / 2) ? d : MAX - d;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            if (errors <= 40)
                $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int value);
        @(posedge clk_usb);
        #1;
        phase_i    = 16'(value);
        phase_ld_i = 1'b1;
        @(posedge clk_usb);
        #1;
        phase_ld_i = 1'b0;
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk_usb);
            n++;
        end while (busy_o && n < budget);
        checkOutput(name, 32'(busy_o), 0);
    endtask

    task automatic waitPsen(input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk_usb);
            n++;
        end while (!psen_o && n < budget);
        checkOutput(name, 32'(psen_o), 1);
    endtask

    // MMCM model: PSDONE comes back PS_DELAY cycles after each PSEN unless muted.
    always @(posedge clk_usb) begin
        #1;
        psdone_i = 1'b0;
        if (countdown > 0) begin
            countdown--;
            if (countdown == 0) psdone_i = 1'b1;
        end
        if (psen_o && respond) countdown = PS_DELAY;
    end

    // Reference model of the phase circle, compared with the DUT every cycle.
    always @(negedge clk_usb) begin
        bit clip;
        bit n_busy;
        int nt;
        cyc++;
        if (model_on) begin
            checkOutput("phase_current", 32'(phase_current_o), m_current);
            checkOutput("busy", 32'(busy_o), 32'(m_busy));
            checkOutput("done", 32'(done_o), 32'(m_done_due == cyc));
            checkOutput("err", 32'(err_o), 32'(m_err));
            if (psen_o) begin
                psen_count++;
                checkOutput("psen_legal", 1,
                            32'(m_locked_prev && m_busy && !m_in_flight && (m_current != m_target)));
                checkOutput("psincdec", 32'(psincdec_o), 32'(inc_dir(m_current, m_target)));
                m_in_flight = 1'b1;
                m_step_dir  = inc_dir(m_current, m_target);
                m_psen_cyc  = cyc;
            end
            if (done_o) done_count++;

            n_busy = m_busy;
            if (!mmcm_locked_i) begin
                m_current   = 0;
                n_busy      = 1'b0;
                m_done_due  = -1;
                m_retarget  = 1'b0;
                m_in_flight = 1'b0;
            end else begin
                if (m_done_due == cyc) n_busy = 1'b0;
                if (phase_ld_i) begin
                    nt       = norm_phase(int'(phase_i), clip);
                    m_target = nt;
                    m_err    = {clip, 1'b0};
                    if (!m_busy || m_done_due == cyc) begin
                        n_busy = 1'b1;
                        if (m_target == m_current) m_done_due = cyc + 2;
                    end else begin
                        m_retarget = 1'b1;
                    end
                end
                if (psdone_i && m_in_flight) begin
                    m_current   = (m_current + (m_step_dir ? 1 : MAX - 1)) % MAX;
                    m_in_flight = 1'b0;
                    if (m_retarget) begin
                        m_retarget = 1'b0;
                        if (m_current == m_target) m_done_due = cyc + 2;
                    end else if (m_current == m_target) begin
                        m_done_due = cyc + 1;
                    end
                end else if (m_in_flight && (cyc - m_psen_cyc) >= TIMEOUT) begin
                    m_in_flight = 1'b0;
                    m_retarget  = 1'b0;
                    n_busy      = 1'b0;
                    m_err[0]    = 1'b1;
                end
            end
            m_busy = n_busy;
        end
        m_locked_prev = mmcm_locked_i;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0;
        int d0;
        int tgt;
        int nt;
        bit clip;

        repeat (3) @(posedge clk_usb);
        #1;
        phase_i    = 16'sd7;
        phase_ld_i = 1'b1;
        @(posedge clk_usb);
        #1;
        phase_ld_i = 1'b0;
        @(negedge clk_usb);
        checkOutput("reset_psen", 32'(psen_o), 0);
        checkOutput("reset_psincdec", 32'(psincdec_o), 0);
        checkOutput("reset_current", 32'(phase_current_o), 0);
        checkOutput("reset_busy", 32'(busy_o), 0);
        checkOutput("reset_done", 32'(done_o), 0);
        checkOutput("reset_err", 32'(err_o), 0);
        @(posedge clk_usb);
        #1;
        reset_n  = 1'b1;
        model_on = 1'b1;

        $display("[TB] load 5 from 0");
        p0 = psen_count; d0 = done_count;
        applyStimulus(5);
        waitIdle(2000, "t1_settle");
        checkOutput("t1_current", 32'(phase_current_o), 5);
        checkOutput("t1_psen_count", psen_count - p0, 5);
        checkOutput("t1_done_count", done_count - d0, 1);
        checkOutput("t1_err", 32'(err_o), 0);

        $display("[TB] zero-distance load");
        p0 = psen_count; d0 = done_count;
        applyStimulus(5);
        waitIdle(20, "t1z_settle");
        checkOutput("t1z_psen_count", psen_count - p0, 0);
        checkOutput("t1z_done_count", done_count - d0, 1);

        $display("[TB] from 2 load -3");
        applyStimulus(2);
        waitIdle(2000, "t2a_settle");
        p0 = psen_count; d0 = done_count;
        applyStimulus(-3);
        waitIdle(2000, "t2_settle");
        checkOutput("t2_current", 32'(phase_current_o), 1117);
        checkOutput("t2_psen_count", psen_count - p0, 5);
        checkOutput("t2_done_count", done_count - d0, 1);

        $display("[TB] from 0 load 561");
        applyStimulus(0);
        waitIdle(2000, "t3a_settle");
        p0 = psen_count;
        applyStimulus(561);
        waitIdle(12000, "t3_settle");
        checkOutput("t3_current", 32'(phase_current_o), 561);
        checkOutput("t3_psen_count", psen_count - p0, 559);

        $display("[TB] unlock to zero, then load 2000");
        @(posedge clk_usb);
        #1;
        mmcm_locked_i = 1'b0;
        repeat (3) @(posedge clk_usb);
        #1;
        mmcm_locked_i = 1'b1;
        @(negedge clk_usb);
        checkOutput("t4_unlock_current", 32'(phase_current_o), 0);
        p0 = psen_count;
        applyStimulus(2000);
        waitIdle(2000, "t4_settle");
        checkOutput("t4_current", 32'(phase_current_o), 1119);
        checkOutput("t4_err", 32'(err_o), 2);
        checkOutput("t4_psen_count", psen_count - p0, 1);

        $display("[TB] retarget 100 -> 30 while stepping from 40");
        applyStimulus(40);
        waitIdle(2000, "t5a_settle");
        p0 = psen_count; d0 = done_count;
        applyStimulus(100);
        waitPsen(20, "t5_first_psen");
        repeat (2) @(posedge clk_usb);
        applyStimulus(30);
        waitIdle(2000, "t5_settle");
        checkOutput("t5_current", 32'(phase_current_o), 30);
        checkOutput("t5_psen_count", psen_count - p0, 12);
        checkOutput("t5_done_count", done_count - d0, 1);

        $display("[TB] load coinciding with psdone");
        p0 = psen_count; d0 = done_count;
        applyStimulus(50);
        waitPsen(20, "t5b_first_psen");
        repeat (PS_DELAY - 1) @(posedge clk_usb);
        applyStimulus(20);
        waitIdle(2000, "t5b_settle");
        checkOutput("t5b_current", 32'(phase_current_o), 20);
        checkOutput("t5b_psen_count", psen_count - p0, 12);
        checkOutput("t5b_done_count", done_count - d0, 1);

        $display("[TB] psdone never returns");
        respond = 1'b0;
        p0 = psen_count; d0 = done_count;
        applyStimulus(10);
        waitIdle(400, "t6_settle");
        checkOutput("t6_err", 32'(err_o), 1);
        checkOutput("t6_current", 32'(phase_current_o), 20);
        checkOutput("t6_psen_count", psen_count - p0, 1);
        checkOutput("t6_done_count", done_count - d0, 0);
        respond = 1'b1;

        $display("[TB] lock lost mid-move");
        applyStimulus(300);
        waitPsen(20, "t7_psen1");
        waitPsen(30, "t7_psen2");
        waitPsen(30, "t7_psen3");
        @(posedge clk_usb);
        #1;
        mmcm_locked_i = 1'b0;
        repeat (2) @(negedge clk_usb);
        checkOutput("t7_current", 32'(phase_current_o), 0);
        checkOutput("t7_busy", 32'(busy_o), 0);
        p0 = psen_count;
        applyStimulus(77);
        repeat (30) @(negedge clk_usb);
        checkOutput("t7_psen_count", psen_count - p0, 0);
        checkOutput("t7_busy_after_load", 32'(busy_o), 0);
        @(posedge clk_usb);
        #1;
        mmcm_locked_i = 1'b1;

        $display("[TB] random moves");
        for (int i = 0; i < 24; i++) begin
            if (i % 8 == 7) tgt = int'($urandom_range(0, 4000)) - 1500;
            else            tgt = m_current + int'($urandom_range(0, 60)) - 30;
            nt = norm_phase(tgt, clip);
            applyStimulus(tgt);
            if (steps_between(m_current, nt) != 0 && $urandom_range(0, 2) == 0) begin
                waitPsen(20, "rnd_first_psen");
                repeat ($urandom_range(0, 9)) @(posedge clk_usb);
                applyStimulus(m_current + int'($urandom_range(0, 40)) - 20);
            end
            waitIdle(10000, "rnd_settle");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
